// File: rtl/child_stream_aggregator.sv
// Merges result words from NUM_CH child channels into one tagged stream.
// Round-robin arbitration feeds a small FIFO that drains through a valid/ready port.
module child_stream_aggregator #(
    parameter int NUM_CH     = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int SRC_W     = $clog2(NUM_CH),
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [SRC_W-1:0]           out_src,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           fifo_count,
    output logic [15:0]                accept_total
);

    logic [SRC_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       total;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [SRC_W-1:0]  mem_src  [FIFO_DEPTH];

    logic              grant_valid;
    logic [SRC_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              can_push;
    logic              push;
    logic              pop;
    logic [SRC_W-1:0]  rr_next;

    // Scan channels starting at rr_ptr, wrapping at NUM_CH rather than 2^SRC_W.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_valid && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(idx);
                grant_data  = in_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    // A pop in the same cycle does not free a slot for this cycle's push.
    assign can_push = (count != CNT_W'(FIFO_DEPTH));
    assign push     = grant_valid && can_push && !rst;
    assign out_valid = (count != '0);
    assign pop      = out_valid && out_ready;
    assign rr_next  = (grant_idx == SRC_W'(NUM_CH - 1)) ? '0 : grant_idx + SRC_W'(1);

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= grant_data;
            mem_src[wr_ptr]  <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            total  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= rr_next;
                total  <= total + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data     = out_valid ? mem_data[rd_ptr] : '0;
    assign out_src      = out_valid ? mem_src[rd_ptr]  : '0;
    assign fifo_count   = count;
    assign accept_total = total;

endmodule
